// File: rtl/sim_halt_monitor.sv
// Simulation halt monitor: stops a run on PC breakpoint, cycle timeout or (optionally) a self-loop.
// Optional feature: define SIM_HALT_SELFLOOP_EN to enable self-loop detection (cause 2'b11).
module sim_halt_monitor #(
    parameter int unsigned  NUM_BP     = 4,
    parameter int unsigned  CNT_W      = 32,
    parameter int unsigned  MAX_CYCLES = 100000,
    parameter int unsigned  LOOP_LIMIT = 8,
    parameter logic [31:0]  RESET_BP0  = 32'h0000_000c,
    localparam int unsigned BP_W       = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [31:0]      pcW,
    input  logic             pcW_valid,
    input  logic             bp_we,
    input  logic [BP_W-1:0]  bp_sel,
    input  logic [31:0]      bp_addr,
    input  logic             bp_en,
    input  logic             clr,
    output logic             done,
    output logic [1:0]       cause,
    output logic [BP_W-1:0]  hit_idx,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_BP   = 2'b01;
    localparam logic [1:0] CAUSE_TO   = 2'b10;
    localparam logic [1:0] CAUSE_LOOP = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             done_q, done_d;
    logic [1:0]       cause_q, cause_d;
    logic [BP_W-1:0]  hit_idx_q, hit_idx_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] retire_q, retire_d;

    logic [31:0]       bp_addr_q [NUM_BP];
    logic [NUM_BP-1:0] bp_en_q;

    logic             bp_hit_c;
    logic [BP_W-1:0]  bp_idx_c;
    logic             loop_hit_c;
    logic             active_c;
    logic             running_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == {CNT_W{1'b1}}) ? x : x + CNT_W'(1);
    endfunction

    assign active_c = (state_q != HALTED);

    // Lowest enabled index wins: scan downward so the last assignment is the lowest.
    always_comb begin
        bp_hit_c = 1'b0;
        bp_idx_c = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_en_q[i] && (bp_addr_q[i] == pcW)) begin
                bp_hit_c = 1'b1;
                bp_idx_c = BP_W'(i);
            end
        end
    end

    // Breakpoint registers survive clr; out-of-range selects match no index.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_BP; i++) begin
                bp_addr_q[i] <= (i == 0) ? RESET_BP0 : 32'h0;
            end
            bp_en_q <= NUM_BP'(1);
        end else if (bp_we) begin
            for (int i = 0; i < NUM_BP; i++) begin
                if (bp_sel == BP_W'(i)) begin
                    bp_addr_q[i] <= bp_addr;
                    bp_en_q[i]   <= bp_en;
                end
            end
        end
    end

`ifdef SIM_HALT_SELFLOOP_EN
    localparam int unsigned LOOP_W = (LOOP_LIMIT > 0) ? $clog2(LOOP_LIMIT + 1) : 1;

    logic [31:0]       last_pc_q, last_pc_d;
    logic [LOOP_W-1:0] loop_cnt_q, loop_cnt_d;

    // Run length of identical retired PCs; bubbles leave it untouched.
    always_comb begin
        last_pc_d  = last_pc_q;
        loop_cnt_d = loop_cnt_q;
        loop_hit_c = 1'b0;
        if (clr) begin
            loop_cnt_d = '0;
        end else if (pcW_valid && active_c) begin
            last_pc_d = pcW;
            if ((loop_cnt_q != '0) && (pcW == last_pc_q)) begin
                if (loop_cnt_q != LOOP_W'(LOOP_LIMIT)) begin
                    loop_cnt_d = loop_cnt_q + LOOP_W'(1);
                end
            end else begin
                loop_cnt_d = LOOP_W'(1);
            end
            loop_hit_c = (loop_cnt_d == LOOP_W'(LOOP_LIMIT));
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_pc_q  <= 32'h0;
            loop_cnt_q <= '0;
        end else begin
            last_pc_q  <= last_pc_d;
            loop_cnt_q <= loop_cnt_d;
        end
    end
`else
    assign loop_hit_c = 1'b0;
`endif

    // Next-state and output logic; clr overrides every halt condition.
    always_comb begin
        state_d   = state_q;
        done_d    = done_q;
        cause_d   = cause_q;
        hit_idx_d = hit_idx_q;
        cycle_d   = cycle_q;
        retire_d  = retire_q;
        running_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (pcW_valid) begin
                    running_c = 1'b1;
                    state_d   = RUN;
                    cycle_d   = sat_inc(cycle_q);
                    retire_d  = sat_inc(retire_q);
                end
            end
            RUN: begin
                running_c = 1'b1;
                cycle_d   = sat_inc(cycle_q);
                if (pcW_valid) begin
                    retire_d = sat_inc(retire_q);
                end
            end
            HALTED: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (running_c) begin
            if (pcW_valid && bp_hit_c) begin
                state_d   = HALTED;
                done_d    = 1'b1;
                cause_d   = CAUSE_BP;
                hit_idx_d = bp_idx_c;
            end else if (loop_hit_c) begin
                state_d = HALTED;
                done_d  = 1'b1;
                cause_d = CAUSE_LOOP;
            end else if ((MAX_CYCLES != 0) && (64'(cycle_d) == 64'(MAX_CYCLES))) begin
                state_d = HALTED;
                done_d  = 1'b1;
                cause_d = CAUSE_TO;
            end
        end

        if (clr) begin
            state_d   = IDLE;
            done_d    = 1'b0;
            cause_d   = CAUSE_NONE;
            hit_idx_d = '0;
            cycle_d   = '0;
            retire_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            done_q    <= 1'b0;
            cause_q   <= CAUSE_NONE;
            hit_idx_q <= '0;
            cycle_q   <= '0;
            retire_q  <= '0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            cause_q   <= cause_d;
            hit_idx_q <= hit_idx_d;
            cycle_q   <= cycle_d;
            retire_q  <= retire_d;
        end
    end

    assign done       = done_q;
    assign cause      = cause_q;
    assign hit_idx    = hit_idx_q;
    assign cycle_cnt  = cycle_q;
    assign retire_cnt = retire_q;

endmodule

// File: tb/tb_sim_halt_monitor.sv
// Directed self-checking bench for sim_halt_monitor (honours SIM_HALT_SELFLOOP_EN if defined).
module tb_sim_halt_monitor;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] pcW;
    logic        pcW_valid;
    logic        bp_we;
    logic [1:0]  bp_sel;
    logic [31:0] bp_addr;
    logic        bp_en;
    logic        clr;

    logic        done;
    logic [1:0]  cause;
    logic [1:0]  hit_idx;
    logic [31:0] cycle_cnt;
    logic [31:0] retire_cnt;

    logic        s_done;
    logic [1:0]  s_cause;
    logic [1:0]  s_hit_idx;
    logic [2:0]  s_cycle_cnt;
    logic [2:0]  s_retire_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sim_halt_monitor #(
        .NUM_BP(4), .CNT_W(32), .MAX_CYCLES(20), .LOOP_LIMIT(8), .RESET_BP0(32'h0000_000c)
    ) dut (
        .clk(clk), .rstn(rstn), .pcW(pcW), .pcW_valid(pcW_valid),
        .bp_we(bp_we), .bp_sel(bp_sel), .bp_addr(bp_addr), .bp_en(bp_en), .clr(clr),
        .done(done), .cause(cause), .hit_idx(hit_idx),
        .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
    );

    // Narrow-counter instance: saturation without timeout or reachable breakpoint.
    sim_halt_monitor #(
        .NUM_BP(4), .CNT_W(3), .MAX_CYCLES(0), .LOOP_LIMIT(1000), .RESET_BP0(32'hffff_fff0)
    ) u_sat (
        .clk(clk), .rstn(rstn), .pcW(pcW), .pcW_valid(pcW_valid),
        .bp_we(1'b0), .bp_sel(2'b00), .bp_addr(32'h0), .bp_en(1'b0), .clr(clr),
        .done(s_done), .cause(s_cause), .hit_idx(s_hit_idx),
        .cycle_cnt(s_cycle_cnt), .retire_cnt(s_retire_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc);
        pcW_valid = v;
        pcW       = pc;
        tick();
    endtask

    task automatic wr_bp(input logic [1:0] sel, input logic [31:0] a, input logic en);
        bp_we     = 1'b1;
        bp_sel    = sel;
        bp_addr   = a;
        bp_en     = en;
        pcW_valid = 1'b0;
        tick();
        bp_we     = 1'b0;
    endtask

    task automatic do_clr();
        clr       = 1'b1;
        pcW_valid = 1'b0;
        tick();
        clr       = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; pcW = 32'h0; pcW_valid = 1'b0;
        bp_we = 1'b0; bp_sel = 2'b00; bp_addr = 32'h0; bp_en = 1'b0; clr = 1'b0;
        tick();
        tick();
        chk("rst_done",   64'(done), 64'd0);
        chk("rst_cause",  64'(cause), 64'd0);
        chk("rst_hit",    64'(hit_idx), 64'd0);
        chk("rst_cycle",  64'(cycle_cnt), 64'd0);
        chk("rst_retire", 64'(retire_cnt), 64'd0);
        rstn = 1'b1;

        // Default bp0 = 0xc hits on the fourth retirement
        drive(1'b1, 32'h0);
        chk("t1_first_cycle",  64'(cycle_cnt), 64'd1);
        chk("t1_first_retire", 64'(retire_cnt), 64'd1);
        drive(1'b1, 32'h4);
        drive(1'b1, 32'h8);
        chk("t1_pre_done", 64'(done), 64'd0);
        drive(1'b1, 32'hc);
        chk("t1_done",   64'(done), 64'd1);
        chk("t1_cause",  64'(cause), 64'd1);
        chk("t1_hit",    64'(hit_idx), 64'd0);
        chk("t1_retire", 64'(retire_cnt), 64'd4);
        chk("t1_cycle",  64'(cycle_cnt), 64'd4);
        drive(1'b1, 32'h100);
        drive(1'b1, 32'h104);
        chk("t1_frz_cycle",  64'(cycle_cnt), 64'd4);
        chk("t1_frz_retire", 64'(retire_cnt), 64'd4);
        chk("t1_frz_cause",  64'(cause), 64'd1);
        do_clr();
        chk("clr_done",   64'(done), 64'd0);
        chk("clr_cause",  64'(cause), 64'd0);
        chk("clr_cycle",  64'(cycle_cnt), 64'd0);
        chk("clr_retire", 64'(retire_cnt), 64'd0);

        // bp2 and bp3 both 0x40 (lowest wins), bp0 disabled, bubbles interleaved
        wr_bp(2'd2, 32'h40, 1'b1);
        wr_bp(2'd3, 32'h40, 1'b1);
        wr_bp(2'd0, 32'hc, 1'b0);
        begin
            logic [31:0] pcs [13];
            logic        vs  [13];
            pcs = '{32'h0, 32'h4, 32'h8, 32'hc, 32'h40, 32'h10, 32'h14,
                    32'h0, 32'h18, 32'h1c, 32'h14, 32'h20, 32'h40};
            vs  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                    1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
            for (int i = 0; i < 13; i++) begin
                if (i == 6) begin
                    bp_we = 1'b1; bp_sel = 2'd1; bp_addr = 32'h14; bp_en = 1'b1;
                end
                drive(vs[i], pcs[i]);
                bp_we = 1'b0;
                if (i == 3) chk("t2_bp0_disabled", 64'(done), 64'd0);
                if (i == 4) chk("t2_bubble_nohit", 64'(done), 64'd0);
                if (i == 6) chk("t2_same_cycle_wr", 64'(done), 64'd0);
            end
        end
        chk("t2_done",   64'(done), 64'd1);
        chk("t2_cause",  64'(cause), 64'd1);
        chk("t2_hit",    64'(hit_idx), 64'd2);
        chk("t2_cycle",  64'(cycle_cnt), 64'd13);
        chk("t2_retire", 64'(retire_cnt), 64'd10);
        do_clr();

        // Breakpoints retained across clr; hit on the very first retirement
        drive(1'b1, 32'h40);
        chk("t2b_done",   64'(done), 64'd1);
        chk("t2b_hit",    64'(hit_idx), 64'd2);
        chk("t2b_cycle",  64'(cycle_cnt), 64'd1);
        chk("t2b_retire", 64'(retire_cnt), 64'd1);
        do_clr();

        // Timeout at 20 cycles with 5 bubbles
        for (int i = 0; i < 20; i++) begin
            drive((i % 4) != 3, 32'h1000 + 32'(4 * i));
            if (i == 18) begin
                chk("t3_pre_done",  64'(done), 64'd0);
                chk("t3_pre_cycle", 64'(cycle_cnt), 64'd19);
            end
        end
        chk("t3_done",   64'(done), 64'd1);
        chk("t3_cause",  64'(cause), 64'd2);
        chk("t3_cycle",  64'(cycle_cnt), 64'd20);
        chk("t3_retire", 64'(retire_cnt), 64'd15);
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h3000 + 32'(4 * i));
        chk("t3_frz_cycle",  64'(cycle_cnt), 64'd20);
        chk("t3_frz_retire", 64'(retire_cnt), 64'd15);
        chk("sat_cycle",  64'(s_cycle_cnt), 64'd7);
        chk("sat_retire", 64'(s_retire_cnt), 64'd7);
        chk("sat_done",   64'(s_done), 64'd0);
        do_clr();

        // Repeated 0x20 with a differing PC and a bubble in the stream
        for (int i = 0; i < 16; i++) begin
            drive(i != 10, (i == 6) ? 32'h30 : 32'h20);
            if (i == 14) chk("t4_pre_done", 64'(done), 64'd0);
        end
`ifdef SIM_HALT_SELFLOOP_EN
        chk("t4_done",   64'(done), 64'd1);
        chk("t4_cause",  64'(cause), 64'd3);
        chk("t4_cycle",  64'(cycle_cnt), 64'd16);
        chk("t4_retire", 64'(retire_cnt), 64'd15);
`else
        chk("t4_noloop_done", 64'(done), 64'd0);
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h20);
        chk("t4_done",   64'(done), 64'd1);
        chk("t4_cause",  64'(cause), 64'd2);
        chk("t4_cycle",  64'(cycle_cnt), 64'd20);
        chk("t4_retire", 64'(retire_cnt), 64'd19);
`endif
        do_clr();

        // Async reset in the middle of a run
        for (int i = 0; i < 7; i++) drive(1'b1, 32'h2000 + 32'(4 * i));
        chk("t5_cycle7", 64'(cycle_cnt), 64'd7);
        #2 rstn = 1'b0;
        #1;
        chk("t5_rst_done",   64'(done), 64'd0);
        chk("t5_rst_cause",  64'(cause), 64'd0);
        chk("t5_rst_hit",    64'(hit_idx), 64'd0);
        chk("t5_rst_cycle",  64'(cycle_cnt), 64'd0);
        chk("t5_rst_retire", 64'(retire_cnt), 64'd0);
        pcW_valid = 1'b0;
        tick();
        rstn = 1'b1;
        drive(1'b1, 32'hc);
        chk("t5_bp0_done",  64'(done), 64'd1);
        chk("t5_bp0_cause", 64'(cause), 64'd1);
        chk("t5_bp0_hit",   64'(hit_idx), 64'd0);
        do_clr();

        // clr outranks a simultaneous breakpoint match
        clr = 1'b1; pcW_valid = 1'b1; pcW = 32'hc;
        tick();
        clr = 1'b0;
        chk("t6_clr_prio_done",  64'(done), 64'd0);
        chk("t6_clr_prio_cycle", 64'(cycle_cnt), 64'd0);
        // bp2 was cleared by reset
        drive(1'b1, 32'h40);
        chk("t6_bp2_cleared", 64'(done), 64'd0);
        chk("t6_retire",      64'(retire_cnt), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
